// File: rtl/cnn_conv_acc_relu.sv
// -----------------------------------------------------------------------------
// cnn_conv_acc_relu
//
// Sits after the conv1 multiplier and turns a stream of signed products into
// one activation per convolution window.
//   - Accepts TAPS products per window. The first product of a window is added
//     to the per-kernel bias, which is lifted to product scale.
//   - The final sum is rescaled by an arithmetic right shift of FRAC_SHIFT and
//     then clamped to the OUT_W range.
//   - The result is presented over a valid/ready handshake.
//
// Build option:
//   CNN_ACC_RELU_EN  defined     -> lower clamp is 0 (ReLU)
//                    not defined -> lower clamp is -2^(OUT_W-1) (signed saturation)
//   Latency and handshake behaviour are the same in both builds.
//
// Ports:
//   ap_clk      in   1       clock; all logic uses the rising edge
//   ap_rst_n    in   1       asynchronous reset, active-low
//   bias        in   BIAS_W  signed bias, sampled together with tap 0
//   prod_data   in   PROD_W  signed product from the multiplier
//   prod_valid  in   1       prod_data is valid
//   prod_ready  out  1       a product is accepted this cycle (high only in S_ACC)
//   out_data    out  OUT_W   signed activation
//   out_valid   out  1       out_data is valid (high only in S_OUT)
//   out_ready   in   1       the consumer takes out_data
//   tap_cnt     out  5       number of taps accepted in the current window (debug)
// -----------------------------------------------------------------------------
module cnn_conv_acc_relu #(
    parameter int PROD_W     = 22,
    parameter int ACC_W      = 32,
    parameter int BIAS_W     = 14,
    parameter int OUT_W      = 14,
    parameter int TAPS       = 25,
    parameter int FRAC_SHIFT = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [BIAS_W-1:0] bias,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        tap_cnt
);

    typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

    localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);

    // Clamp limits, expressed at accumulator width so they can be compared
    // directly against the scaled sum.
    localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
`ifdef CNN_ACC_RELU_EN
    localparam logic signed [ACC_W-1:0] OUT_LO = '0;
`else
    // Inverting 2^(n-1)-1 gives -2^(n-1).
    localparam logic signed [ACC_W-1:0] OUT_LO = ~OUT_HI;
`endif

    state_t state, state_nxt;

    logic                    accept;
    logic                    consume;
    logic                    last_tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_scaled;
    logic signed [ACC_W-1:0] sum_base;
    logic signed [ACC_W-1:0] final_sum;
    logic signed [ACC_W-1:0] scaled;
    logic        [OUT_W-1:0] clamped;

    assign accept   = prod_valid && prod_ready;
    assign consume  = out_valid && out_ready;
    assign last_tap = accept && (tap_cnt == LAST_TAP);

    // Sign-extend both operands before the add. The bias is moved up to
    // product scale so it survives the final downshift unchanged.
    assign prod_ext    = ACC_W'($signed(prod_data));
    assign bias_scaled = ACC_W'($signed(bias)) <<< FRAC_SHIFT;
    // Tap 0 starts from the scaled bias, which discards any earlier sum.
    assign sum_base    = (tap_cnt == 5'd0) ? bias_scaled : acc;
    assign final_sum   = sum_base + prod_ext;
    // Arithmetic shift, so the result rounds toward minus infinity.
    assign scaled      = final_sum >>> FRAC_SHIFT;

    always_comb begin
        // NOTE: assign a default first so that no path through this block leaves
        // the output unassigned, which would infer a latch.
        clamped = scaled[OUT_W-1:0];
        if (scaled > OUT_HI) begin
            clamped = OUT_HI[OUT_W-1:0];
        end else if (scaled < OUT_LO) begin
            clamped = OUT_LO[OUT_W-1:0];
        end
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: use non-blocking assignments for all flops so that every
        // register samples its pre-edge value, whatever order the code is in.
        if (!ap_rst_n) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (last_tap) state_nxt = S_OUT;
            S_OUT:   if (consume)  state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        prod_ready = (state == S_ACC);
        out_valid  = (state == S_OUT);
    end

    // Datapath. out_data is loaded on the edge that accepts the last tap, so it
    // is already valid in the first cycle of S_OUT. It then holds until the
    // next window completes.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc      <= '0;
            tap_cnt  <= '0;
            out_data <= '0;
        end else if (accept) begin
            acc <= final_sum;
            if (last_tap) begin
                tap_cnt  <= '0;
                out_data <= clamped;
            end else begin
                tap_cnt <= tap_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// -----------------------------------------------------------------------------
// tb_cnn_conv_acc_relu
//
// Directed bench for cnn_conv_acc_relu with the default parameters
// (TAPS=25, FRAC_SHIFT=8, OUT_W=14). Expected values are worked out by hand
// for each scenario. Inputs change 1 ns after the rising edge, and outputs
// are read at that same point, once the edge's updates have settled.
// -----------------------------------------------------------------------------
module tb_cnn_conv_acc_relu;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [13:0] bias;
    logic [21:0] prod_data;
    logic        prod_valid;
    logic        prod_ready;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  tap_cnt;

    int total = 0;
    int bad   = 0;

    cnn_conv_acc_relu dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .bias      (bias),
        .prod_data (prod_data),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tap_cnt   (tap_cnt)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Drives n back-to-back products. The caller must ensure prod_ready stays high.
    task automatic drive_taps(input logic [13:0] b, input logic [21:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bias       = b;
            prod_data  = d;
            prod_valid = 1'b1;
            step();
        end
        prod_valid = 1'b0;
    endtask

    task automatic consume_output();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (out_data !== 14'd0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        total++;
        if (tap_cnt !== 5'd0) begin bad++; $display("FAIL reset_tap_cnt got=%0d exp=0", tap_cnt); end
        total++;
        if (prod_ready !== 1'b1) begin bad++; $display("FAIL reset_prod_ready got=%b exp=1", prod_ready); end
        ap_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive_taps(14'd0, 22'd256, 24);
        total++;
        if (tap_cnt !== 5'd24) begin bad++; $display("FAIL basic_tap24 got=%0d exp=24", tap_cnt); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        drive_taps(14'd0, 22'd256, 1);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
        total++;
        if (out_data !== 14'd25) begin bad++; $display("FAIL basic_out_data got=%0d exp=25", out_data); end
        total++;
        if (tap_cnt !== 5'd0) begin bad++; $display("FAIL basic_tap_wrap got=%0d exp=0", tap_cnt); end
        total++;
        if (prod_ready !== 1'b0) begin bad++; $display("FAIL basic_prod_ready got=%b exp=0", prod_ready); end
        consume_output();
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1) begin
            bad++; $display("FAIL basic_consume got valid=%b ready=%b exp valid=0 ready=1", out_valid, prod_ready);
        end
    endtask

    task automatic test_negative();
        logic [13:0] exp_v;
`ifdef CNN_ACC_RELU_EN
        exp_v = 14'h0000;
`else
        exp_v = 14'h3FF6;
`endif
        drive_taps(14'h3FF6, 22'd0, 25);
        total++;
        if (out_valid !== 1'b1 || out_data !== exp_v) begin
            bad++; $display("FAIL negative got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, exp_v);
        end
        consume_output();
    endtask

    task automatic test_saturation();
        logic [13:0] exp_lo;
`ifdef CNN_ACC_RELU_EN
        exp_lo = 14'h0000;
`else
        exp_lo = 14'h2000;
`endif
        drive_taps(14'd0, 22'h1FFFFF, 25);
        total++;
        if (out_data !== 14'h1FFF) begin bad++; $display("FAIL sat_hi got=%h exp=1fff", out_data); end
        consume_output();
        drive_taps(14'd0, 22'h200000, 25);
        total++;
        if (out_data !== exp_lo) begin bad++; $display("FAIL sat_lo got=%h exp=%h", out_data, exp_lo); end
        consume_output();
    endtask

    task automatic test_backpressure();
        drive_taps(14'd0, 22'd256, 25);
        // The upstream keeps offering a distinctive product that must not be taken.
        prod_data  = 22'd4096;
        prod_valid = 1'b1;
        out_ready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== 14'd25 || prod_ready !== 1'b0 || tap_cnt !== 5'd0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%0d ready=%b tap=%0d exp 1/25/0/0",
                         i, out_valid, out_data, prod_ready, tap_cnt);
            end
        end
        prod_valid = 1'b0;
        consume_output();
        // Tap 0 of the new window is 512, with bias 0. The sum is 512 + 24*256 = 6656, giving 26.
        drive_taps(14'd0, 22'd512, 1);
        total++;
        if (tap_cnt !== 5'd1) begin bad++; $display("FAIL bp_new_tap got=%0d exp=1", tap_cnt); end
        drive_taps(14'd0, 22'd256, 24);
        total++;
        if (out_data !== 14'd26) begin bad++; $display("FAIL bp_next_window got=%0d exp=26", out_data); end
        consume_output();
    endtask

    task automatic test_bubbles();
        int accepts;
        accepts = 0;
        bias      = 14'd0;
        prod_data = 22'd256;
        for (int c = 0; c < 49; c++) begin
            prod_valid = (c % 2 == 0);
            if (prod_valid) accepts++;
            step();
            if (accepts < 25) begin
                total++;
                if (tap_cnt !== 5'(accepts)) begin
                    bad++; $display("FAIL bubble_tap[%0d] got=%0d exp=%0d", c, tap_cnt, accepts);
                end
            end
        end
        prod_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 14'd25) begin
            bad++; $display("FAIL bubble_result got valid=%b data=%0d exp valid=1 data=25", out_valid, out_data);
        end
        consume_output();
    endtask

    task automatic test_reset_mid();
        drive_taps(14'd100, 22'd256, 12);
        ap_rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b0 || tap_cnt !== 5'd0 || out_data !== 14'd0) begin
                bad++;
                $display("FAIL rst_mid[%0d] got valid=%b tap=%0d data=%0d exp 0/0/0", i, out_valid, tap_cnt, out_data);
            end
            step();
        end
        ap_rst_n = 1'b1;
        step();
        drive_taps(14'd0, 22'd256, 25);
        total++;
        if (out_valid !== 1'b1 || out_data !== 14'd25) begin
            bad++; $display("FAIL rst_mid_window got valid=%b data=%0d exp valid=1 data=25", out_valid, out_data);
        end
        consume_output();
    endtask

    task automatic test_back_to_back();
        // out_ready is held high throughout. It has no effect while accumulating.
        out_ready = 1'b1;
        drive_taps(14'd0, 22'd256, 25);
        total++;
        if (out_valid !== 1'b1 || out_data !== 14'd25) begin
            bad++; $display("FAIL b2b_first got valid=%b data=%0d exp valid=1 data=25", out_valid, out_data);
        end
        prod_data  = 22'd512;
        prod_valid = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || prod_ready !== 1'b1 || tap_cnt !== 5'd0) begin
            bad++;
            $display("FAIL b2b_gap got valid=%b ready=%b tap=%0d exp 0/1/0", out_valid, prod_ready, tap_cnt);
        end
        drive_taps(14'd0, 22'd512, 25);
        total++;
        if (out_valid !== 1'b1 || out_data !== 14'd50) begin
            bad++; $display("FAIL b2b_second got valid=%b data=%0d exp valid=1 data=50", out_valid, out_data);
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        bias       = '0;
        prod_data  = '0;
        prod_valid = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
